// File: rtl/tpu_weight_sequencer.sv
// ============================================================================
// tpu_weight_sequencer
//
// Sequences weight rows for a double-buffered systolic-array weight buffer.
// A load FSM streams rows from the weight stream into the shadow bank. A
// compute FSM swaps the banks and then issues row reads to the array. A new
// load can fill the shadow bank while the active bank is still being read.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   load_start/load_k request to fill the shadow bank with load_k rows
//   ld_valid/ld_data  weight-stream beat; ld_ready is high while loading
//   compute_start/k   request to swap banks and stream compute_k rows
//   compute_busy      compute FSM is not idle
//   compute_done      one-cycle pulse, the cycle after the final wb_rd_valid
//   shadow_full       shadow bank holds a complete layer
//   err               one-cycle pulse, registered: it appears in the cycle
//                     after a rejected load_start or compute_start
//   wb_wr_*           buffer write port, driven in the cycle of each beat
//   wb_rd_*           buffer read request / read-data valid
//   wb_swap_banks     one-cycle bank-swap pulse
//   perf_rows         rows streamed to the array
//
// Build option
//   TPU_WSEQ_PERF_EN  when defined, perf_rows counts wb_rd_en cycles and
//                     wraps at 2^32; otherwise perf_rows is tied to 0.
// ============================================================================
module tpu_weight_sequencer #(
    parameter int ARRAY_SIZE = 8,
    parameter int MAX_K      = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int KW         = $clog2(MAX_K) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_start,
    input  logic [KW-1:0]              load_k,
    input  logic                       ld_valid,
    input  logic [ARRAY_SIZE*2-1:0]    ld_data,
    output logic                       ld_ready,
    input  logic                       compute_start,
    input  logic [KW-1:0]              compute_k,
    output logic                       compute_busy,
    output logic                       compute_done,
    output logic                       shadow_full,
    output logic                       err,
    output logic                       wb_wr_en,
    output logic [ADDR_WIDTH-1:0]      wb_wr_addr,
    output logic [ARRAY_SIZE*2-1:0]    wb_wr_data,
    output logic                       wb_rd_en,
    output logic [$clog2(MAX_K)-1:0]   wb_rd_row,
    input  logic                       wb_rd_valid,
    output logic                       wb_swap_banks,
    output logic [31:0]                perf_rows
);

    localparam int RW = $clog2(MAX_K);

    localparam logic [0:0] L_IDLE  = 1'b0;
    localparam logic [0:0] L_LOAD  = 1'b1;

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SWAP  = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_DRAIN = 2'd3;

    logic [0:0]    l_state;
    logic [KW-1:0] load_len;
    logic [RW-1:0] beat_idx;

    logic [1:0]    c_state;
    logic [KW-1:0] comp_len;
    logic [RW-1:0] rd_row;
    logic [RW-1:0] valid_cnt;

    logic          shadow_full_q;
    logic          err_q;
    logic          done_q;

    // ------------------------------------------------------------------
    // Request qualification. Both requests are judged on the state held
    // before this edge, so a simultaneous load/compute pair never sees
    // the effect of the other.
    // ------------------------------------------------------------------
    logic load_k_ok;
    logic compute_k_ok;
    logic load_accept;
    logic compute_accept;
    logic load_reject;
    logic compute_reject;

    assign load_k_ok      = (load_k != '0) && (load_k <= KW'(MAX_K));
    assign compute_k_ok   = (compute_k != '0) && (compute_k <= KW'(MAX_K));
    assign load_accept    = load_start && (l_state == L_IDLE) && !shadow_full_q && load_k_ok;
    assign compute_accept = compute_start && (c_state == C_IDLE) && shadow_full_q && compute_k_ok;
    assign load_reject    = load_start && !load_accept;
    assign compute_reject = compute_start && !compute_accept;

    logic beat;
    logic last_beat;
    logic last_read;
    logic final_valid;

    assign beat        = (l_state == L_LOAD) && ld_valid;
    assign last_beat   = beat && (KW'(beat_idx) == load_len - KW'(1));
    assign last_read   = (c_state == C_READ) && (KW'(rd_row) == comp_len - KW'(1));
    // Read data can already return while reads are still being issued,
    // so valid beats are counted in both C_READ and C_DRAIN.
    assign final_valid = ((c_state == C_READ) || (c_state == C_DRAIN)) && wb_rd_valid
                         && (KW'(valid_cnt) == comp_len - KW'(1));

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge value of its neighbours, regardless of ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_state  <= L_IDLE;
            load_len <= '0;
            beat_idx <= '0;
        end else begin
            case (l_state)
                L_IDLE: begin
                    if (load_accept) begin
                        l_state  <= L_LOAD;
                        load_len <= load_k;
                        beat_idx <= '0;
                    end
                end
                default: begin
                    if (last_beat) begin
                        l_state  <= L_IDLE;
                        beat_idx <= '0;
                    end else if (beat) begin
                        beat_idx <= beat_idx + RW'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Compute FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_state   <= C_IDLE;
            comp_len  <= '0;
            rd_row    <= '0;
            valid_cnt <= '0;
        end else begin
            case (c_state)
                C_IDLE: begin
                    if (compute_accept) begin
                        c_state  <= C_SWAP;
                        comp_len <= compute_k;
                    end
                end
                C_SWAP: begin
                    c_state   <= C_READ;
                    rd_row    <= '0;
                    valid_cnt <= '0;
                end
                C_READ: begin
                    if (wb_rd_valid) valid_cnt <= valid_cnt + RW'(1);
                    if (final_valid) begin
                        c_state <= C_IDLE;
                    end else if (last_read) begin
                        c_state <= C_DRAIN;
                    end else begin
                        rd_row  <= rd_row + RW'(1);
                    end
                end
                default: begin
                    if (wb_rd_valid) valid_cnt <= valid_cnt + RW'(1);
                    if (final_valid) c_state <= C_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shadow-bank status and pulses. The swap empties the shadow bank;
    // a load cannot be finishing in the swap cycle because shadow_full
    // blocks load acceptance until the swap has cleared it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_full_q <= 1'b0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            if (last_beat)
                shadow_full_q <= 1'b1;
            else if (c_state == C_SWAP)
                shadow_full_q <= 1'b0;
            err_q  <= load_reject || compute_reject;
            done_q <= final_valid;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ld_ready      = (l_state == L_LOAD);
    assign wb_wr_en      = beat;
    assign wb_wr_addr    = ADDR_WIDTH'(beat_idx);
    assign wb_wr_data    = ld_data;
    assign wb_rd_en      = (c_state == C_READ);
    assign wb_rd_row     = rd_row;
    assign wb_swap_banks = (c_state == C_SWAP);
    assign compute_busy  = (c_state != C_IDLE);
    assign compute_done  = done_q;
    assign shadow_full   = shadow_full_q;
    assign err           = err_q;

`ifdef TPU_WSEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_q <= '0;
        else if (wb_rd_en)
            perf_q <= perf_q + 32'd1;
    end

    assign perf_rows = perf_q;
`else
    assign perf_rows = 32'd0;
`endif

endmodule

// File: tb/tb_tpu_weight_sequencer.sv
// ============================================================================
// tb_tpu_weight_sequencer
//
// Bench for tpu_weight_sequencer with default parameters. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge. Expected
// buffer writes and reads are queued when stimulus is driven and checked as
// the sequencer produces them. The bench plays the buffer: wb_rd_valid
// follows wb_rd_en by one cycle.
// ============================================================================
module tb_tpu_weight_sequencer;

    localparam int AS    = 8;
    localparam int MAXK  = 256;
    localparam int AW    = 16;
    localparam int KW    = $clog2(MAXK) + 1;
    localparam int DW    = AS * 2;
    localparam int RW    = $clog2(MAXK);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic [KW-1:0] load_k;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          compute_start;
    logic [KW-1:0] compute_k;
    logic          compute_busy;
    logic          compute_done;
    logic          shadow_full;
    logic          err;
    logic          wb_wr_en;
    logic [AW-1:0] wb_wr_addr;
    logic [DW-1:0] wb_wr_data;
    logic          wb_rd_en;
    logic [RW-1:0] wb_rd_row;
    logic          wb_rd_valid;
    logic          wb_swap_banks;
    logic [31:0]   perf_rows;

    tpu_weight_sequencer #(
        .ARRAY_SIZE (AS),
        .MAX_K      (MAXK),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_k        (load_k),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .compute_start (compute_start),
        .compute_k     (compute_k),
        .compute_busy  (compute_busy),
        .compute_done  (compute_done),
        .shadow_full   (shadow_full),
        .err           (err),
        .wb_wr_en      (wb_wr_en),
        .wb_wr_addr    (wb_wr_addr),
        .wb_wr_data    (wb_wr_data),
        .wb_rd_en      (wb_rd_en),
        .wb_rd_row     (wb_rd_row),
        .wb_rd_valid   (wb_rd_valid),
        .wb_swap_banks (wb_swap_banks),
        .perf_rows     (perf_rows)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           wr_q[$];
    logic [RW-1:0] rd_q[$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    logic rd_en_d     = 1'b0;
    int   perf_exp    = 0;

    // Everything that should be 0 while reset is asserted.
    function automatic logic [63:0] reset_outs();
        return {shadow_full, ld_ready, compute_busy, compute_done, err,
                wb_wr_en, wb_rd_en, wb_swap_banks, wb_wr_addr, wb_rd_row, perf_rows};
    endfunction

    // Falling-edge sample: retire scoreboard entries for this cycle.
    task automatic sample_cycle();
        wr_t           we;
        logic [RW-1:0] re;
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (wb_wr_en !== 1'b0) begin
                vectors++;
                if (wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected: got addr=%0h data=%0h, no write expected", wb_wr_addr, wb_wr_data);
                end else begin
                    we = wr_q.pop_front();
                    if ({wb_wr_addr, wb_wr_data} !== we) begin
                        miscompares++;
                        $display("FAIL wr_beat: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                                 wb_wr_addr, wb_wr_data, we.addr, we.data);
                    end
                end
            end
            if (wb_rd_en !== 1'b0) begin
                vectors++;
                if (rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_unexpected: got row=%0d, no read expected", wb_rd_row);
                end else begin
                    re = rd_q.pop_front();
                    if (wb_rd_row !== re) begin
                        miscompares++;
                        $display("FAIL rd_row: got %0d, expected %0d", wb_rd_row, re);
                    end
                end
            end
            if (compute_done === 1'b1) done_cnt++;
        end
        rd_en_d = (wb_rd_en === 1'b1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        wb_rd_valid = rd_en_d && (rst_n === 1'b1);
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drained: %0d writes and %0d reads outstanding, expected 0 and 0",
                     name, wr_q.size(), rd_q.size());
        end
    endtask

    task automatic push_rows(input int k);
        for (int r = 0; r < k; r++) rd_q.push_back(RW'(r));
    endtask

    task automatic test_reset();
        rst_n = 1'b1; load_start = 0; load_k = '0; ld_valid = 0; ld_data = '0;
        compute_start = 0; compute_k = '0; wb_rd_valid = 0;
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if (reset_outs() !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, expected 0", reset_outs());
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sample_cycle();
        vectors++;
        if (shadow_full !== 1'b0 || ld_ready !== 1'b0 || compute_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: sf=%b rdy=%b busy=%b, expected 0 0 0", shadow_full, ld_ready, compute_busy);
        end
        next_cycle();
    endtask

    // A rejected request: err exactly in the following cycle, nothing else moves.
    task automatic run_reject(input bit is_load, input logic [KW-1:0] k,
                              input logic sf_exp, input string name);
        if (is_load) begin load_start = 1'b1; load_k = k; end
        else begin compute_start = 1'b1; compute_k = k; end
        for (int c = 0; c < 3; c++) begin
            sample_cycle();
            vectors++;
            if (err !== 1'(c == 1) || ld_ready !== 1'b0 || compute_busy !== 1'b0 ||
                wb_swap_banks !== 1'b0 || shadow_full !== sf_exp) begin
                miscompares++;
                $display("FAIL %s c%0d: err=%b rdy=%b busy=%b swap=%b sf=%b, expected err=%b rdy=0 busy=0 swap=0 sf=%b",
                         name, c, err, ld_ready, compute_busy, wb_swap_banks, shadow_full, 1'(c == 1), sf_exp);
            end
            next_cycle();
            load_start = 1'b0; compute_start = 1'b0;
        end
    endtask

    task automatic test_ignore_valid();
        ld_valid = 1'b1; ld_data = 16'hDEAD;
        for (int c = 0; c < 2; c++) begin
            sample_cycle();
            vectors++;
            if (wb_wr_en !== 1'b0 || ld_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_valid: wr_en=%b rdy=%b, expected 0 0", wb_wr_en, ld_ready);
            end
            next_cycle();
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_load(input int k, input string name);
        load_start = 1'b1; load_k = KW'(k);
        sample_cycle();
        next_cycle();
        load_start = 1'b0;
        for (int b = 0; b < k; b++) begin
            ld_valid = 1'b1;
            ld_data  = DW'($urandom);
            wr_q.push_back({AW'(b), ld_data});
            sample_cycle();
            vectors++;
            if (ld_ready !== 1'b1 || shadow_full !== 1'b0) begin
                miscompares++;
                $display("FAIL %s beat%0d: rdy=%b sf=%b, expected 1 0", name, b, ld_ready, shadow_full);
            end
            next_cycle();
        end
        ld_valid = 1'b0;
        sample_cycle();
        vectors++;
        if (shadow_full !== 1'b1 || ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s full: sf=%b rdy=%b, expected 1 0", name, shadow_full, ld_ready);
        end
        next_cycle();
        check_drained(name);
    endtask

    task automatic test_compute();
        int d0;
        d0 = done_cnt;
        compute_start = 1'b1; compute_k = KW'(4);
        push_rows(4);
        for (int c = 0; c < 9; c++) begin
            sample_cycle();
            vectors++;
            if (wb_swap_banks !== 1'(c == 1) || compute_done !== 1'(c == 7) ||
                compute_busy !== 1'(c >= 1 && c <= 6) || shadow_full !== 1'(c < 2) ||
                wb_rd_en !== 1'(c >= 2 && c <= 5) || wb_rd_valid !== 1'(c >= 3 && c <= 6) || err !== 1'b0) begin
                miscompares++;
                $display("FAIL compute c%0d: swap=%b done=%b busy=%b sf=%b rd_en=%b rd_valid=%b err=%b, expected %b %b %b %b %b %b 0",
                         c, wb_swap_banks, compute_done, compute_busy, shadow_full, wb_rd_en, wb_rd_valid, err,
                         1'(c == 1), 1'(c == 7), 1'(c >= 1 && c <= 6), 1'(c < 2),
                         1'(c >= 2 && c <= 5), 1'(c >= 3 && c <= 6));
            end
            next_cycle();
            compute_start = 1'b0;
        end
        perf_exp += 4;
        check_drained("compute");
        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL compute_done_count: got %0d, expected 1", done_cnt - d0);
        end
        test_perf("perf_after_compute");
    endtask

    task automatic test_perf(input string name);
        logic [31:0] exp;
`ifdef TPU_WSEQ_PERF_EN
        exp = 32'(perf_exp);
`else
        exp = 32'd0;
`endif
        vectors++;
        if (perf_rows !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, perf_rows, exp);
        end
    endtask

    // Load of MAX_K rows started in the first C_READ cycle of a 16-row compute.
    task automatic test_overlap();
        int beats;
        int d0;
        beats = 0;
        d0 = done_cnt;
        for (int c = 0; c < 261; c++) begin
            compute_start = (c == 0); compute_k = KW'(16);
            load_start    = (c == 2); load_k = KW'(MAXK);
            ld_valid      = (c >= 3 && beats < MAXK);
            ld_data       = DW'($urandom);
            if (ld_valid) wr_q.push_back({AW'(beats), ld_data});
            if (c == 0) push_rows(16);
            sample_cycle();
            if (c == 3) begin
                vectors++;
                if (wb_wr_en !== 1'b1 || wb_rd_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL overlap_interleave: wr_en=%b rd_en=%b, expected 1 1", wb_wr_en, wb_rd_en);
                end
            end
            if (c == 19) begin
                vectors++;
                if (compute_done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL overlap_done: got %b at cycle 19, expected 1", compute_done);
                end
            end
            if (c == 258 || c == 259) begin
                vectors++;
                if (shadow_full !== 1'(c == 259)) begin
                    miscompares++;
                    $display("FAIL overlap_full c%0d: got %b, expected %b", c, shadow_full, 1'(c == 259));
                end
            end
            if (ld_valid) beats++;
            next_cycle();
        end
        compute_start = 1'b0; load_start = 1'b0; ld_valid = 1'b0;
        perf_exp += 16;
        check_drained("overlap");
        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL overlap_done_count: got %0d, expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_simultaneous();
        load_start = 1'b1; load_k = KW'(4);
        compute_start = 1'b1; compute_k = KW'(4);
        push_rows(4);
        for (int c = 0; c < 9; c++) begin
            sample_cycle();
            vectors++;
            if (err !== 1'(c == 1) || wb_swap_banks !== 1'(c == 1) ||
                ld_ready !== 1'b0 || compute_done !== 1'(c == 7)) begin
                miscompares++;
                $display("FAIL simultaneous c%0d: err=%b swap=%b rdy=%b done=%b, expected %b %b 0 %b",
                         c, err, wb_swap_banks, ld_ready, compute_done, 1'(c == 1), 1'(c == 1), 1'(c == 7));
            end
            next_cycle();
            load_start = 1'b0; compute_start = 1'b0;
        end
        perf_exp += 4;
        check_drained("simultaneous");
        test_perf("perf_after_simultaneous");
    endtask

    // Reset asserted during read row 2 while a load is also in flight.
    task automatic test_reset_mid();
        test_load(4, "load_pre_reset");
        for (int c = 0; c < 5; c++) begin
            compute_start = (c == 0); compute_k = KW'(4);
            load_start    = (c == 2); load_k = KW'(8);
            ld_valid      = (c >= 3);
            ld_data       = DW'($urandom);
            if (ld_valid) wr_q.push_back({AW'(c - 3), ld_data});
            if (c == 0) push_rows(4);
            sample_cycle();
            if (c < 4) next_cycle();
        end
        vectors++;
        if (wb_rd_en !== 1'b1 || wb_rd_row !== RW'(2) || ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_state: rd_en=%b row=%0d rdy=%b, expected 1 2 1", wb_rd_en, wb_rd_row, ld_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (reset_outs() !== 64'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h, expected 0", reset_outs());
        end
        wr_q.delete(); rd_q.delete();
        compute_start = 1'b0; load_start = 1'b0; ld_valid = 1'b0;
        wb_rd_valid = 1'b0; rd_en_d = 1'b0;
        perf_exp = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_reject(1'b0, KW'(4), 1'b0, "compute_after_reset");
        test_perf("perf_after_reset");
    endtask

    initial begin
        test_reset();
        test_ignore_valid();
        run_reject(1'b0, KW'(4), 1'b0, "compute_not_full");
        run_reject(1'b1, KW'(0), 1'b0, "load_k_zero");
        run_reject(1'b1, KW'(MAXK + 1), 1'b0, "load_k_over");
        test_load(4, "load_basic");
        run_reject(1'b1, KW'(4), 1'b1, "load_when_full");
        test_compute();
        test_load(16, "load_16");
        test_overlap();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tpu_weight_sequencer.md
TPU_WEIGHT_SEQUENCER -- requirements
Module: tpu_weight_sequencer

Interface
REQ-001 Parameters SHALL be: ARRAY_SIZE, default 8, systolic array dimension; MAX_K, default 256, rows per bank; ADDR_WIDTH, default 16, buffer write-address width; KW, default $clog2(MAX_K)+1, width of row-count fields.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- load_start  in  1  request to fill the shadow bank
- load_k  in  KW  rows to load
- ld_valid  in  1  weight-stream beat valid
- ld_data  in  ARRAY_SIZE*2  one weight row
- ld_ready  out  1  sequencer accepts the beat
- compute_start  in  1  request to swap banks and stream rows
- compute_k  in  KW  rows to stream
- compute_busy  out  1  compute sequence in progress
- compute_done  out  1  one-cycle completion pulse
- shadow_full  out  1  shadow bank holds a complete layer
- err  out  1  one-cycle pulse on a rejected request
- wb_wr_en  out  1  buffer write enable
- wb_wr_addr  out  ADDR_WIDTH  buffer write row
- wb_wr_data  out  ARRAY_SIZE*2  buffer write data
- wb_rd_en  out  1  buffer read enable
- wb_rd_row  out  $clog2(MAX_K)  buffer read row
- wb_rd_valid  in  1  buffer read-data valid
- wb_swap_banks  out  1  buffer bank-swap pulse
- perf_rows  out  32  rows streamed to the array

Function
REQ-003 Load FSM SHALL have states L_IDLE and L_LOAD; compute FSM SHALL have states C_IDLE, C_SWAP, C_READ and C_DRAIN.
REQ-004 Acceptance of load_start SHALL require L_IDLE, shadow_full=0, and 1<=load_k<=MAX_K; the FSM then moves to L_LOAD and latches load_k.
REQ-005 In L_LOAD, ld_ready SHALL be 1; each ld_valid&ld_ready beat SHALL drive, in the same cycle, wb_wr_en=1, wb_wr_addr=beat index (0-based), and wb_wr_data=ld_data.
REQ-006 On the load_k-th beat, the load FSM SHALL return to L_IDLE and shadow_full SHALL be 1 from the next cycle.
REQ-007 Acceptance of compute_start SHALL require C_IDLE, shadow_full=1, and 1<=compute_k<=MAX_K.
REQ-008 Accepted compute_start in cycle T SHALL produce:
- wb_swap_banks=1 for exactly cycle T+1 (C_SWAP)
- shadow_full=0 from T+2
- wb_rd_en=1 with wb_rd_row=0..compute_k-1 in cycles T+2..T+1+compute_k (C_READ)
- C_DRAIN until the final wb_rd_valid
- compute_done=1 for the one cycle after the final wb_rd_valid
REQ-009 compute_busy SHALL be 1 in every state except C_IDLE.
REQ-010 A load may run while the compute FSM is in C_READ or C_DRAIN.
REQ-011 Every rejected load_start or compute_start SHALL pulse err for one cycle, with no other effect; this covers a zero count, a count above MAX_K, a busy FSM, load_start with shadow_full=1, and compute_start with shadow_full=0.
REQ-012 When load_start and compute_start arrive together, each SHALL be judged on pre-cycle state; with shadow_full=1, compute is accepted and load is rejected with err.
REQ-013 ld_valid outside L_LOAD SHALL be ignored (ld_ready=0, no write).

Reset
REQ-014 Assertion of rst_n=0 SHALL asynchronously force, including mid-load or mid-compute:
- both FSMs to idle
- shadow_full, ld_ready, compute_busy, compute_done, err, wb_wr_en, wb_rd_en and wb_swap_banks to 0
- wb_wr_addr, wb_rd_row and perf_rows to 0
REQ-015 After reset, shadow_full=0 and the first legal operation SHALL be a load.

Configuration
REQ-016 With macro TPU_WSEQ_PERF_EN defined, perf_rows SHALL increment by 1 per wb_rd_en cycle and wrap at 2^32.
REQ-017 Without TPU_WSEQ_PERF_EN, perf_rows SHALL be constant 0 and no counter logic SHALL be built; the port list is identical in both cases.

Verification
REQ-018 Check a basic load: reset, then load_start with load_k=4, then four ld_valid beats with data A,B,C,D -> wb_wr_addr 0..3 carry A..D, and shadow_full=1 the cycle after beat 4.
REQ-019 Check compute timing: after REQ-018, compute_start with compute_k=4 in cycle 0 -> swap in cycle 1, wb_rd_en in cycles 2-5 with rows 0-3, wb_rd_valid in cycles 3-6, compute_done in cycle 7, shadow_full=0 from cycle 2.
REQ-020 Check overlap: a second load_start with load_k=MAX_K during C_READ -> accepted, writes interleave with reads, and shadow_full=1 after beat 256.
REQ-021 Check rejections -> each pulses err once with no state change:
- compute_start with shadow_full=0
- load_start with load_k=0
- load_start with load_k=MAX_K+1
- load_start with shadow_full=1
REQ-022 Check simultaneous requests: load_start and compute_start together with shadow_full=1 -> compute proceeds and err pulses.
REQ-023 Check reset mid-operation: rst_n low during C_READ row 2 -> all outputs are 0 immediately; after release, compute_start pulses err.
REQ-024 Check the perf counter: with TPU_WSEQ_PERF_EN defined, perf_rows=4 after REQ-019; without it, perf_rows=0.
